// File: rtl/inst_encoder_pkg.sv
// Shared RV32I constants: opcodes, funct3/funct7, operation enum values, field widths.
package inst_encoder_pkg;
  localparam int DATA_W   = 32;
  localparam int REG_W    = 5;
  localparam int INST_W   = 32;
  localparam int OPENUM_W = 6;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [2:0] F3_BEQ = 3'd0, F3_BNE = 3'd1, F3_BLT = 3'd4;
  localparam logic [2:0] F3_BGE = 3'd5, F3_BLTU = 3'd6, F3_BGEU = 3'd7;
  localparam logic [2:0] F3_B = 3'd0, F3_H = 3'd1, F3_W = 3'd2, F3_BU = 3'd4, F3_HU = 3'd5;
  localparam logic [2:0] F3_ADD = 3'd0, F3_SLL = 3'd1, F3_SLT = 3'd2, F3_SLTU = 3'd3;
  localparam logic [2:0] F3_XOR = 3'd4, F3_SR = 3'd5, F3_OR = 3'd6, F3_AND = 3'd7;

  localparam logic [INST_W-1:0] INST_NOP = 32'h0000_0013;

  localparam logic [OPENUM_W-1:0]
    OP_NOP = 6'd0, OP_LUI = 6'd1, OP_AUIPC = 6'd2, OP_JAL = 6'd3, OP_JALR = 6'd4,
    OP_BEQ = 6'd5, OP_BNE = 6'd6, OP_BLT = 6'd7, OP_BGE = 6'd8, OP_BLTU = 6'd9, OP_BGEU = 6'd10,
    OP_LB = 6'd11, OP_LH = 6'd12, OP_LW = 6'd13, OP_LBU = 6'd14, OP_LHU = 6'd15,
    OP_SB = 6'd16, OP_SH = 6'd17, OP_SW = 6'd18,
    OP_ADDI = 6'd19, OP_SLTI = 6'd20, OP_SLTIU = 6'd21, OP_XORI = 6'd22, OP_ORI = 6'd23,
    OP_ANDI = 6'd24, OP_SLLI = 6'd25, OP_SRLI = 6'd26, OP_SRAI = 6'd27,
    OP_ADD = 6'd28, OP_SUB = 6'd29, OP_SLL = 6'd30, OP_SLT = 6'd31, OP_SLTU = 6'd32,
    OP_XOR = 6'd33, OP_SRL = 6'd34, OP_SRA = 6'd35, OP_OR = 6'd36, OP_AND = 6'd37;

  typedef enum logic [2:0] {FMT_NOP, FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_U, FMT_J} fmt_e;

  // True when imm equals the sign-extension of imm[msb:0].
  function automatic logic imm_fits(input logic [DATA_W-1:0] imm, input int unsigned msb);
    logic [DATA_W-1:0] mask;
    mask = {DATA_W{1'b1}} << msb;
    return ((imm & mask) == '0) || ((imm & mask) == mask);
  endfunction
endpackage

// File: rtl/inst_encoder_fifo.sv
// enc_fifo: circular queue with wrapping pointers and a count; flush beats push/pop.
// Output reads as zero while empty so reset and flush leave a clean bus.
module enc_fifo #(
  parameter int W     = 33,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = AW + 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;
  assign dout_o  = empty_o ? '0 : mem_q[rptr_q];

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push_ok) wptr_d = wptr_q + 1'b1;
      if (pop_ok)  rptr_d = rptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !flush_i) mem_q[wptr_q] <= din_i;
  end
endmodule

// File: rtl/inst_encoder.sv
// Encodes decoded RV32I fields into instruction words and queues them (1-cycle latency).
// INST_ENC_RANGE_CHECK_EN adds immediate range checking onto out_err.
module inst_encoder
  import inst_encoder_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [OPENUM_W-1:0] in_openum,
  input  logic [REG_W-1:0]    in_rd,
  input  logic [REG_W-1:0]    in_rs1,
  input  logic [REG_W-1:0]    in_rs2,
  input  logic [DATA_W-1:0]   in_imm,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [INST_W-1:0]   out_inst,
  output logic                out_err
);
  fmt_e              fmt;
  logic [6:0]        opc, f7;
  logic [2:0]        f3;
  logic              undef;
  logic [INST_W-1:0] enc_inst;
  logic              enc_err;
  logic              fifo_full, fifo_empty;

  always_comb begin
    fmt = FMT_NOP; opc = OPC_OPIMM; f3 = F3_ADD; f7 = F7_BASE; undef = 1'b0;
    enc_inst = INST_NOP;
    case (in_openum)
      OP_NOP:   fmt = FMT_NOP;
      OP_LUI:   begin fmt = FMT_U; opc = OPC_LUI; end
      OP_AUIPC: begin fmt = FMT_U; opc = OPC_AUIPC; end
      OP_JAL:   begin fmt = FMT_J; opc = OPC_JAL; end
      OP_JALR:  begin fmt = FMT_I; opc = OPC_JALR; end
      OP_BEQ:   begin fmt = FMT_B; opc = OPC_BRANCH; f3 = F3_BEQ; end
      OP_BNE:   begin fmt = FMT_B; opc = OPC_BRANCH; f3 = F3_BNE; end
      OP_BLT:   begin fmt = FMT_B; opc = OPC_BRANCH; f3 = F3_BLT; end
      OP_BGE:   begin fmt = FMT_B; opc = OPC_BRANCH; f3 = F3_BGE; end
      OP_BLTU:  begin fmt = FMT_B; opc = OPC_BRANCH; f3 = F3_BLTU; end
      OP_BGEU:  begin fmt = FMT_B; opc = OPC_BRANCH; f3 = F3_BGEU; end
      OP_LB:    begin fmt = FMT_I; opc = OPC_LOAD; f3 = F3_B; end
      OP_LH:    begin fmt = FMT_I; opc = OPC_LOAD; f3 = F3_H; end
      OP_LW:    begin fmt = FMT_I; opc = OPC_LOAD; f3 = F3_W; end
      OP_LBU:   begin fmt = FMT_I; opc = OPC_LOAD; f3 = F3_BU; end
      OP_LHU:   begin fmt = FMT_I; opc = OPC_LOAD; f3 = F3_HU; end
      OP_SB:    begin fmt = FMT_S; opc = OPC_STORE; f3 = F3_B; end
      OP_SH:    begin fmt = FMT_S; opc = OPC_STORE; f3 = F3_H; end
      OP_SW:    begin fmt = FMT_S; opc = OPC_STORE; f3 = F3_W; end
      OP_ADDI:  begin fmt = FMT_I; f3 = F3_ADD; end
      OP_SLTI:  begin fmt = FMT_I; f3 = F3_SLT; end
      OP_SLTIU: begin fmt = FMT_I; f3 = F3_SLTU; end
      OP_XORI:  begin fmt = FMT_I; f3 = F3_XOR; end
      OP_ORI:   begin fmt = FMT_I; f3 = F3_OR; end
      OP_ANDI:  begin fmt = FMT_I; f3 = F3_AND; end
      OP_SLLI:  begin fmt = FMT_SH; f3 = F3_SLL; end
      OP_SRLI:  begin fmt = FMT_SH; f3 = F3_SR; end
      OP_SRAI:  begin fmt = FMT_SH; f3 = F3_SR; f7 = F7_ALT; end
      OP_ADD:   begin fmt = FMT_R; opc = OPC_OP; f3 = F3_ADD; end
      OP_SUB:   begin fmt = FMT_R; opc = OPC_OP; f3 = F3_ADD; f7 = F7_ALT; end
      OP_SLL:   begin fmt = FMT_R; opc = OPC_OP; f3 = F3_SLL; end
      OP_SLT:   begin fmt = FMT_R; opc = OPC_OP; f3 = F3_SLT; end
      OP_SLTU:  begin fmt = FMT_R; opc = OPC_OP; f3 = F3_SLTU; end
      OP_XOR:   begin fmt = FMT_R; opc = OPC_OP; f3 = F3_XOR; end
      OP_SRL:   begin fmt = FMT_R; opc = OPC_OP; f3 = F3_SR; end
      OP_SRA:   begin fmt = FMT_R; opc = OPC_OP; f3 = F3_SR; f7 = F7_ALT; end
      OP_OR:    begin fmt = FMT_R; opc = OPC_OP; f3 = F3_OR; end
      OP_AND:   begin fmt = FMT_R; opc = OPC_OP; f3 = F3_AND; end
      default:  undef = 1'b1;
    endcase

    case (fmt)
      FMT_R:   enc_inst = {f7, in_rs2, in_rs1, f3, in_rd, opc};
      FMT_I:   enc_inst = {in_imm[11:0], in_rs1, f3, in_rd, opc};
      FMT_SH:  enc_inst = {f7, in_imm[4:0], in_rs1, f3, in_rd, opc};
      FMT_S:   enc_inst = {in_imm[11:5], in_rs2, in_rs1, f3, in_imm[4:0], opc};
      FMT_B:   enc_inst = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, f3, in_imm[4:1], in_imm[11], opc};
      FMT_U:   enc_inst = {in_imm[31:12], in_rd, opc};
      FMT_J:   enc_inst = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, opc};
      default: enc_inst = INST_NOP;
    endcase

    enc_err = undef;
`ifdef INST_ENC_RANGE_CHECK_EN
    // The word keeps the truncated immediate; only the flag reports the overflow.
    case (fmt)
      FMT_I, FMT_S: enc_err = undef | ~imm_fits(in_imm, 11);
      FMT_B:        enc_err = undef | in_imm[0] | ~imm_fits(in_imm, 12);
      FMT_J:        enc_err = undef | in_imm[0] | ~imm_fits(in_imm, 20);
      FMT_U:        enc_err = undef | (|in_imm[11:0]);
      FMT_SH:       enc_err = undef | (|in_imm[31:5]);
      default:      enc_err = undef;
    endcase
`endif
  end

  assign in_ready  = ~fifo_full & ~flush & ~rst;
  assign out_valid = ~fifo_empty;

  enc_fifo #(.W(INST_W + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (in_valid & in_ready),
    .din_i   ({enc_err, enc_inst}),
    .pop_i   (out_valid & out_ready),
    .flush_i (flush),
    .dout_o  ({out_err, out_inst}),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );
endmodule

// File: tb/tb_inst_encoder.sv
// Directed bench for inst_encoder: queue-based reference model plus literal encodings.
module tb_inst_encoder;
  import inst_encoder_pkg::*;

  localparam int DEPTH = 4;
`ifdef INST_ENC_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, in_ready, flush = 1'b0;
  logic [5:0]  in_openum = '0;
  logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [31:0] in_imm = '0;
  logic        out_valid, out_ready = 1'b0, out_err;
  logic [31:0] out_inst;

  int checks = 0;
  int errors = 0;

  logic [32:0] mq[$];
  logic [31:0] popped[$];
  bit          m_pop, m_push, exp_vld;

  always #5 clk = ~clk;

  inst_encoder #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_openum(in_openum), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_imm(in_imm), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_err(out_err)
  );

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Reference encoder: {err, word} from the RV32I field rules, via plain arithmetic.
  function automatic logic [32:0] model(input logic [5:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [4:0] rs2,
                                        input logic [31:0] imm);
    int k; logic [31:0] opc, f3, f7, w, d, r1, r2; bit bad; int signed s;
    k = 0; opc = 0; f3 = 0; f7 = 0; bad = 0; s = imm; w = 32'h13;
    d = 32'(rd); r1 = 32'(rs1); r2 = 32'(rs2);
    case (op)
      OP_NOP:   k = 8;
      OP_LUI:   begin k = 6; opc = 32'h37; end
      OP_AUIPC: begin k = 6; opc = 32'h17; end
      OP_JAL:   begin k = 7; opc = 32'h6f; end
      OP_JALR:  begin k = 2; opc = 32'h67; end
      OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin k = 5; opc = 32'h63; end
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU:               begin k = 2; opc = 32'h03; end
      OP_SB, OP_SH, OP_SW:                               begin k = 4; opc = 32'h23; end
      OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI: begin k = 2; opc = 32'h13; end
      OP_SLLI, OP_SRLI, OP_SRAI:                         begin k = 3; opc = 32'h13; end
      OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND:
                                                         begin k = 1; opc = 32'h33; end
      default:  k = 0;
    endcase
    case (op)
      OP_BNE, OP_LH, OP_SH, OP_SLLI, OP_SLL:                f3 = 1;
      OP_LW, OP_SW, OP_SLTI, OP_SLT:                        f3 = 2;
      OP_SLTIU, OP_SLTU:                                    f3 = 3;
      OP_BLT, OP_LBU, OP_XORI, OP_XOR:                      f3 = 4;
      OP_BGE, OP_LHU, OP_SRLI, OP_SRAI, OP_SRL, OP_SRA:     f3 = 5;
      OP_BLTU, OP_ORI, OP_OR:                               f3 = 6;
      OP_BGEU, OP_ANDI, OP_AND:                             f3 = 7;
      default:                                              f3 = 0;
    endcase
    if (op == OP_SUB || op == OP_SRA || op == OP_SRAI) f7 = 32'h20;
    case (k)
      1: w = opc | d << 7 | f3 << 12 | r1 << 15 | r2 << 20 | f7 << 25;
      2: begin
        w = opc | d << 7 | f3 << 12 | r1 << 15 | (imm & 32'hfff) << 20;
        bad = s < -2048 || s > 2047;
      end
      3: begin
        w = opc | d << 7 | f3 << 12 | r1 << 15 | (imm & 31) << 20 | f7 << 25;
        bad = imm > 31;
      end
      4: begin
        w = opc | (imm & 31) << 7 | f3 << 12 | r1 << 15 | r2 << 20 | ((imm >> 5) & 127) << 25;
        bad = s < -2048 || s > 2047;
      end
      5: begin
        w = opc | ((imm >> 11) & 1) << 7 | ((imm >> 1) & 15) << 8 | f3 << 12 | r1 << 15
              | r2 << 20 | ((imm >> 5) & 63) << 25 | ((imm >> 12) & 1) << 31;
        bad = imm[0] || s < -4096 || s > 4095;
      end
      6: begin
        w = opc | d << 7 | (imm & 32'hffff_f000);
        bad = (imm & 32'hfff) != 0;
      end
      7: begin
        w = opc | d << 7 | (imm & 32'h000f_f000) | ((imm >> 11) & 1) << 20
              | ((imm >> 1) & 1023) << 21 | ((imm >> 20) & 1) << 31;
        bad = imm[0] || s < -(1 << 20) || s > (1 << 20) - 1;
      end
      default: w = 32'h13;
    endcase
    return {(k == 0) || (RC && bad), w};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) mq.delete();
    else if (flush) mq.delete();
    else begin
      m_pop  = (mq.size() > 0) && out_ready;
      m_push = in_valid && (mq.size() < DEPTH);
      if (m_pop) void'(mq.pop_front());
      if (m_push) mq.push_back(model(in_openum, in_rd, in_rs1, in_rs2, in_imm));
    end
  end

  always @(posedge clk)
    if (!rst && !flush && out_valid && out_ready) popped.push_back(out_inst);

  always @(negedge clk) begin
    exp_vld = !rst && (mq.size() > 0);
    chk1("out_valid", out_valid, exp_vld);
    chk1("in_ready", in_ready, !rst && !flush && (mq.size() < DEPTH));
    if (exp_vld) begin
      chk32("out_inst", out_inst, mq[0][31:0]);
      chk1("out_err", out_err, mq[0][32]);
    end
    if (rst) begin
      chk32("rst out_inst", out_inst, 32'h0);
      chk1("rst out_err", out_err, 1'b0);
    end
  end

  task automatic put(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                     input logic [4:0] rs2, input logic [31:0] imm);
    in_openum = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_valid = 1'b1;
  endtask

  task automatic single(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [31:0] imm,
                        input logic [31:0] exp_inst, input logic exp_err, input string name);
    @(posedge clk); #1; put(op, rd, rs1, rs2, imm);
    @(posedge clk); #1; in_valid = 1'b0;
    @(negedge clk);
    chk1({name, " vld"}, out_valid, 1'b1);
    chk32({name, " inst"}, out_inst, exp_inst);
    chk1({name, " err"}, out_err, exp_err);
    @(posedge clk); #1; out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
  endtask

  logic [5:0]  vop[6]  = '{OP_LW, OP_JALR, OP_AUIPC, OP_AND, OP_SLLI, OP_BLTU};
  logic [31:0] vimm[6] = '{32'hFFFF_FFF8, 32'h0000_07FF, 32'hFFFF_F000, 32'h0, 32'd31, 32'hFFFF_F000};
  logic [31:0] exp_burst[4] = '{32'h00100093, 32'h00200113, 32'h00300193, 32'h00400213};

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk1("reset out_valid", out_valid, 1'b0);
    chk1("reset in_ready", in_ready, 1'b0);
    chk32("reset out_inst", out_inst, 32'h0);
    @(posedge clk); #1; rst = 1'b0;

    single(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd5,  32'h00500093, 1'b0, "addi");
    single(OP_SUB,  5'd3, 5'd1, 5'd2, 32'd0,  32'h402081B3, 1'b0, "sub");
    single(OP_SW,   5'd7, 5'd1, 5'd2, 32'd12, 32'h0020A623, 1'b0, "sw");
    single(OP_BEQ,  5'd9, 5'd1, 5'd2, 32'd8,  32'h00208463, 1'b0, "beq");
    single(OP_JAL,  5'd1, 5'd0, 5'd0, 32'h800, 32'h001000EF, 1'b0, "jal");
    single(OP_LUI,  5'd5, 5'd0, 5'd0, 32'h12345000, 32'h123452B7, 1'b0, "lui");
    single(OP_SRAI, 5'd2, 5'd3, 5'd0, 32'd4,  32'h4041D113, 1'b0, "srai");
    single(OP_BNE,  5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC, 32'hFE209EE3, 1'b0, "bne neg");
    single(OP_NOP,  5'd5, 5'd6, 5'd7, 32'd99, 32'h00000013, 1'b0, "nop");
    single(6'd60,   5'd1, 5'd1, 5'd1, 32'd1,  32'h00000013, 1'b1, "undef");
    single(OP_ADDI, 5'd0, 5'd0, 5'd0, 32'h800, 32'h80000013, RC, "addi range");
    single(OP_BEQ,  5'd0, 5'd1, 5'd2, 32'd3,  32'h00208163, RC, "beq odd");
    single(OP_SLLI, 5'd1, 5'd1, 5'd0, 32'd32, 32'h00009093, RC, "slli range");

    // Streaming with concurrent push and pop, checked by the model only.
    @(posedge clk); #1; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      put(vop[i], 5'(i + 1), 5'(i + 2), 5'd9, vimm[i]);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1; out_ready = 1'b0;

    // Fill to DEPTH with the consumer stalled, then drain in order.
    popped.delete();
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk); #1; put(OP_ADDI, 5'(i), 5'd0, 5'd0, 32'(i));
      if (i == 5) begin
        @(negedge clk);
        chk1("full in_ready", in_ready, 1'b0);
      end
    end
    @(posedge clk); #1; in_valid = 1'b0; out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1; out_ready = 1'b0;
    chk32("drain count", 32'(popped.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      chk32($sformatf("drain word %0d", i), (i < popped.size()) ? popped[i] : 32'hDEAD_DEAD, exp_burst[i]);

    // Flush with a same-cycle push and pop against three queued words.
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk); #1; put(OP_ADDI, 5'(i), 5'd0, 5'd0, 32'(i));
    end
    @(posedge clk); #1; put(OP_ADDI, 5'd7, 5'd0, 5'd0, 32'd7); flush = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    chk1("flush out_valid", out_valid, 1'b0);
    chk1("flush in_ready", in_ready, 1'b1);
    single(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd5, 32'h00500093, 1'b0, "post flush");

    // Reset mid-stream.
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk); #1; put(OP_ADDI, 5'(i), 5'd0, 5'd0, 32'(i));
    end
    @(posedge clk); #1; in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk1("mid rst out_valid", out_valid, 1'b0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk1("post rst out_valid", out_valid, 1'b0);
    chk1("post rst in_ready", in_ready, 1'b1);
    single(OP_SUB, 5'd3, 5'd1, 5'd2, 32'd0, 32'h402081B3, 1'b0, "post rst");

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
